// File: rtl/color_sequencer.sv
// -----------------------------------------------------------------------------
// color_sequencer
//
// Produces per-channel 8-bit duty targets for the RGB PWM stage. Each press
// pulse from the debouncer advances the display mode (OFF, WHEEL, BREATHE,
// WHITE). A prescaled step tick animates a hue wheel or a breathing level.
//
// Parameters:
//   CLK_HZ   input clock frequency in Hz
//   STEP_HZ  animation step rate in Hz (CLK_HZ/STEP_HZ must be >= 2)
//
// Ports:
//   clk        in   1  system clock
//   reset_n    in   1  synchronous, active-low reset
//   f_edge     in   1  one-cycle press pulse; advances the mode
//   r_duty     out  8  red duty target (registered)
//   g_duty     out  8  green duty target (registered)
//   b_duty     out  8  blue duty target (registered)
//   mode       out  2  0 OFF, 1 WHEEL, 2 BREATHE, 3 WHITE (registered)
//   step_tick  out  1  one-cycle pulse per applied animation step (registered)
// -----------------------------------------------------------------------------
module color_sequencer #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned STEP_HZ = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       f_edge,
    output logic [7:0] r_duty,
    output logic [7:0] g_duty,
    output logic [7:0] b_duty,
    output logic [1:0] mode,
    output logic       step_tick
);

    localparam int unsigned DIV = CLK_HZ / STEP_HZ;
    localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2) begin : g_div_check
            $error("color_sequencer: CLK_HZ/STEP_HZ must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_WHEEL   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_WHITE   = 2'd3
    } mode_t;

    // State registers
    mode_t         r_state;
    logic [PW-1:0] r_pcnt;
    logic [7:0]    r_level;
    logic [2:0]    r_seg;
    logic          r_dir;
    logic [7:0]    r_red;
    logic [7:0]    r_green;
    logic [7:0]    r_blue;
    logic          r_tick;

    // Next-state values
    mode_t         w_state_nxt;
    logic [PW-1:0] w_pcnt_nxt;
    logic [7:0]    w_level_nxt;
    logic [2:0]    w_seg_nxt;
    logic          w_dir_nxt;
    logic [7:0]    w_red_nxt;
    logic [7:0]    w_green_nxt;
    logic [7:0]    w_blue_nxt;
    logic          w_tick_nxt;

    logic          w_tick;
    logic [7:0]    w_inv;

    assign w_tick = (r_pcnt == PW'(DIV - 1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= MODE_OFF;
            r_pcnt  <= '0;
            r_level <= '0;
            r_seg   <= '0;
            r_dir   <= 1'b0;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_level <= w_level_nxt;
            r_seg   <= w_seg_nxt;
            r_dir   <= w_dir_nxt;
            r_red   <= w_red_nxt;
            r_green <= w_green_nxt;
            r_blue  <= w_blue_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state: mode, prescaler and animation state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pcnt_nxt  = r_pcnt;
        w_level_nxt = r_level;
        w_seg_nxt   = r_seg;
        w_dir_nxt   = r_dir;
        w_tick_nxt  = 1'b0;

        if (f_edge) begin
            // A press restarts the animation and swallows any coincident tick.
            w_state_nxt = mode_t'(r_state + 2'd1);
            w_pcnt_nxt  = '0;
            w_level_nxt = '0;
            w_seg_nxt   = '0;
            w_dir_nxt   = 1'b0;
        end else begin
            w_pcnt_nxt = w_tick ? '0 : r_pcnt + PW'(1);
            w_tick_nxt = w_tick;
            if (w_tick) begin
                case (r_state)
                    MODE_WHEEL: begin
                        w_level_nxt = r_level + 8'd1;
                        if (r_level == 8'd255) begin
                            w_seg_nxt = (r_seg == 3'd5) ? 3'd0 : r_seg + 3'd1;
                        end
                    end
                    MODE_BREATHE: begin
                        // Direction flips on the step that lands on an
                        // endpoint, so 0 and 255 each appear for one step.
                        if (!r_dir) begin
                            w_level_nxt = r_level + 8'd1;
                            if (r_level == 8'd254) begin
                                w_dir_nxt = 1'b1;
                            end
                        end else begin
                            w_level_nxt = r_level - 8'd1;
                            if (r_level == 8'd1) begin
                                w_dir_nxt = 1'b0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Duty mapping from the next state, so duties register alongside it
    // -------------------------------------------------------------------------
    assign w_inv = ~w_level_nxt;

    always_comb begin
        w_red_nxt   = '0;
        w_green_nxt = '0;
        w_blue_nxt  = '0;
        case (w_state_nxt)
            MODE_WHEEL: begin
                case (w_seg_nxt)
                    3'd0: begin
                        w_red_nxt   = '1;
                        w_green_nxt = w_level_nxt;
                    end
                    3'd1: begin
                        w_red_nxt   = w_inv;
                        w_green_nxt = '1;
                    end
                    3'd2: begin
                        w_green_nxt = '1;
                        w_blue_nxt  = w_level_nxt;
                    end
                    3'd3: begin
                        w_green_nxt = w_inv;
                        w_blue_nxt  = '1;
                    end
                    3'd4: begin
                        w_red_nxt   = w_level_nxt;
                        w_blue_nxt  = '1;
                    end
                    3'd5: begin
                        w_red_nxt   = '1;
                        w_blue_nxt  = w_inv;
                    end
                    default: begin
                    end
                endcase
            end
            MODE_BREATHE: begin
                w_red_nxt   = w_level_nxt;
                w_green_nxt = w_level_nxt;
                w_blue_nxt  = w_level_nxt;
            end
            MODE_WHITE: begin
                w_red_nxt   = '1;
                w_green_nxt = '1;
                w_blue_nxt  = '1;
            end
            default: begin
            end
        endcase
    end

    assign r_duty    = r_red;
    assign g_duty    = r_green;
    assign b_duty    = r_blue;
    assign mode      = r_state;
    assign step_tick = r_tick;

endmodule

// File: tb/tb_color_sequencer.sv
// -----------------------------------------------------------------------------
// tb_color_sequencer
//
// Directed and randomized stimulus for color_sequencer with DIV = 10. The
// reference model tracks mode, cycles since the last mode event and the number
// of applied steps, and derives the expected colour arithmetically from the
// step count (hue position modulo 1536, triangle wave modulo 510).
// -----------------------------------------------------------------------------
module tb_color_sequencer;

    localparam int unsigned CLK_HZ  = 1000;
    localparam int unsigned STEP_HZ = 100;
    localparam int          DIV     = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       f_edge;
    logic [7:0] r_duty;
    logic [7:0] g_duty;
    logic [7:0] b_duty;
    logic [1:0] mode;
    logic       step_tick;

    always #5 clk = ~clk;

    color_sequencer #(
        .CLK_HZ  (CLK_HZ),
        .STEP_HZ (STEP_HZ)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .f_edge    (f_edge),
        .r_duty    (r_duty),
        .g_duty    (g_duty),
        .b_duty    (b_duty),
        .mode      (mode),
        .step_tick (step_tick)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_mode = 0;
    int m_j    = 0;   // clock edges since the last reset / mode change
    int m_n    = 0;   // animation steps since the last reset / mode change
    bit m_tick = 1'b0;

    function automatic logic [23:0] exp_duty(input int md, input int n);
        int h;
        int s;
        int l;
        int p;
        logic [7:0] lv;
        logic [7:0] iv;
        if (md == 0) return 24'h000000;
        if (md == 3) return 24'hFFFFFF;
        if (md == 1) begin
            h  = n % 1536;
            s  = h / 256;
            l  = h % 256;
            lv = 8'(l);
            iv = 8'(255 - l);
            case (s)
                0:       return {8'd255, lv, 8'd0};
                1:       return {iv, 8'd255, 8'd0};
                2:       return {8'd0, 8'd255, lv};
                3:       return {8'd0, iv, 8'd255};
                4:       return {lv, 8'd0, 8'd255};
                default: return {8'd255, 8'd0, iv};
            endcase
        end
        p  = n % 510;
        l  = (p <= 255) ? p : 510 - p;
        lv = 8'(l);
        return {lv, lv, lv};
    endfunction

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%06h expected=%06h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge with the given inputs, model update, then full comparison.
    task automatic step(input logic rn, input logic fe);
        reset_n = rn;
        f_edge  = fe;
        @(posedge clk);
        if (!rn) begin
            m_mode = 0;
            m_j    = 0;
            m_n    = 0;
            m_tick = 1'b0;
        end else if (fe) begin
            m_mode = (m_mode + 1) % 4;
            m_j    = 0;
            m_n    = 0;
            m_tick = 1'b0;
        end else begin
            m_j++;
            if (m_j % DIV == 0) begin
                m_tick = 1'b1;
                m_n++;
            end else begin
                m_tick = 1'b0;
            end
        end
        #1;
        check("mode", 24'(mode), 24'(m_mode));
        check("step_tick", 24'(step_tick), 24'(m_tick));
        check("duty", {r_duty, g_duty, b_duty}, exp_duty(m_mode, m_n));
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b1, 1'b0);
    endtask

    // Run until the model has just applied step number 'target'.
    task automatic run_to(input int target);
        int guard = 0;
        while (m_n < target && guard < 40000) begin
            step(1'b1, 1'b0);
            guard++;
        end
        checks++;
        if (m_n != target) begin
            failures++;
            $error("FAIL run_to observed=%0d expected=%0d", m_n, target);
        end
    endtask

    // Stop so that the next clock edge is one where the prescaler wraps.
    task automatic align_to_tick();
        while ((m_j + 1) % DIV != 0) step(1'b1, 1'b0);
    endtask

    initial begin
        logic [23:0] cyc_duty [4];
        int          tick_cnt;
        logic        rn;
        logic        fe;

        cyc_duty[0] = 24'hFF0000;
        cyc_duty[1] = 24'h000000;
        cyc_duty[2] = 24'hFFFFFF;
        cyc_duty[3] = 24'h000000;

        reset_n = 1'b0;
        f_edge  = 1'b0;

        // Reset, then idle in OFF: ticks pulse every DIV cycles, duties stay 0.
        repeat (3) step(1'b0, 1'b0);
        check("reset_duty", {r_duty, g_duty, b_duty}, 24'h000000);
        check("reset_mode", 24'(mode), 24'd0);
        tick_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0);
            if (step_tick) tick_cnt++;
        end
        check("off_tick_count", 24'(tick_cnt), 24'd3);
        check("off_duty", {r_duty, g_duty, b_duty}, 24'h000000);

        // Mode cycling: 1, 2, 3, 0.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            check("cycle_mode", 24'(mode), 24'((i + 1) % 4));
            check("cycle_duty", {r_duty, g_duty, b_duty}, cyc_duty[i]);
            idle(19);
        end

        // Full WHEEL hue cycle.
        step(1'b1, 1'b1);
        run_to(255);
        check("wheel_t255", {r_duty, g_duty, b_duty}, 24'hFFFF00);
        run_to(257);
        check("wheel_t257", {r_duty, g_duty, b_duty}, 24'hFEFF00);
        run_to(769);
        check("wheel_t769", {r_duty, g_duty, b_duty}, 24'h00FEFF);
        run_to(1536);
        check("wheel_t1536", {r_duty, g_duty, b_duty}, 24'hFF0000);

        // BREATHE bounce.
        step(1'b1, 1'b1);
        check("breathe_entry", {r_duty, g_duty, b_duty}, 24'h000000);
        run_to(255);
        check("breathe_peak", {r_duty, g_duty, b_duty}, 24'hFFFFFF);
        run_to(256);
        check("breathe_t256", {r_duty, g_duty, b_duty}, 24'hFEFEFE);
        run_to(510);
        check("breathe_t510", {r_duty, g_duty, b_duty}, 24'h000000);
        run_to(511);
        check("breathe_t511", {r_duty, g_duty, b_duty}, 24'h010101);

        // Press coincident with a tick in WHEEL at level 37.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        run_to(37);
        check("wheel_l37", {r_duty, g_duty, b_duty}, 24'hFF2500);
        align_to_tick();
        step(1'b1, 1'b1);
        check("coinc_mode", 24'(mode), 24'd2);
        check("coinc_tick", 24'(step_tick), 24'd0);
        check("coinc_duty", {r_duty, g_duty, b_duty}, 24'h000000);
        idle(DIV - 1);
        check("coinc_no_early_tick", 24'(step_tick), 24'd0);
        idle(1);
        check("coinc_next_tick", 24'(step_tick), 24'd1);
        check("coinc_next_level", {r_duty, g_duty, b_duty}, 24'h010101);

        // Reset mid-animation, falling at level 100, with press and tick.
        run_to(410);
        check("breathe_down100", {r_duty, g_duty, b_duty}, 24'h646464);
        align_to_tick();
        step(1'b0, 1'b1);
        check("midrst_mode", 24'(mode), 24'd0);
        check("midrst_tick", 24'(step_tick), 24'd0);
        check("midrst_duty", {r_duty, g_duty, b_duty}, 24'h000000);
        step(1'b1, 1'b1);
        check("midrst_wheel_mode", 24'(mode), 24'd1);
        check("midrst_wheel_duty", {r_duty, g_duty, b_duty}, 24'hFF0000);

        // Randomized presses (including back-to-back) and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 599) != 0);
            fe = ($urandom_range(0, 49) == 0);
            step(rn, fe);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
